// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS connection between the CPU (master) and a memory-mapped responder (slave).
// INTR travels with the bus so a peripheral exposes a single bundle to the CPU.
interface otter_iobus_timer_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN,
        input  INTR
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN,
        output INTR
    );
endinterface

// File: rtl/otter_iobus_timer.sv
// Programmable IOBUS timer: 16-bit prescaler, 32-bit counter with compare match,
// one-shot or auto-reload operation and a level interrupt to the CPU.
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic                   CLK,
    input  logic                   RESET,
    otter_iobus_timer_if.slave     iobus
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic        en, auto_reload, irq_en;
    logic [15:0] prescale, pcnt;
    logic [31:0] compare, count;
    logic        pending;
    logic [31:0] rd_data;
    logic        intr;

    logic        en_n, auto_reload_n, irq_en_n;
    logic [15:0] prescale_n, pcnt_n;
    logic [31:0] compare_n, count_n;
    logic        pending_n;

    logic        hit;
    logic [2:0]  offset;
    logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic        pcnt_wrap, pcnt_clear, tick, match;
    logic [31:0] rd_sel;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^iobus.IOBUS_ADDR[1:0];

    always_comb begin
        hit         = (iobus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
        offset      = iobus.IOBUS_ADDR[4:2];
        wr_ctrl     = hit && iobus.IOBUS_WR && (offset == OFF_CTRL);
        wr_prescale = hit && iobus.IOBUS_WR && (offset == OFF_PRESCALE);
        wr_compare  = hit && iobus.IOBUS_WR && (offset == OFF_COMPARE);
        wr_count    = hit && iobus.IOBUS_WR && (offset == OFF_COUNT);
        wr_status   = hit && iobus.IOBUS_WR && (offset == OFF_STATUS);
    end

    // A prescaler restart suppresses the tick of the same cycle.
    always_comb begin
        pcnt_wrap  = (pcnt == prescale);
        pcnt_clear = (wr_ctrl && !iobus.IOBUS_OUT[0]) || wr_prescale;
        tick       = en && pcnt_wrap && !pcnt_clear;
        match      = tick && (count == compare);
    end

    always_comb begin
        rd_sel = 32'd0;
        case (offset)
            OFF_CTRL:     rd_sel = {29'd0, irq_en, auto_reload, en};
            OFF_PRESCALE: rd_sel = {16'd0, prescale};
            OFF_COMPARE:  rd_sel = compare;
            OFF_COUNT:    rd_sel = count;
            OFF_STATUS:   rd_sel = {31'd0, pending};
            default:      rd_sel = 32'd0;
        endcase
    end

    // CPU writes are applied last so they override any tick-driven update,
    // except that a match always sets PENDING even against a W1C.
    always_comb begin
        en_n          = en;
        auto_reload_n = auto_reload;
        irq_en_n      = irq_en;
        prescale_n    = prescale;
        compare_n     = compare;
        count_n       = count;
        pcnt_n        = pcnt;
        pending_n     = pending;

        if (pcnt_clear)
            pcnt_n = 16'd0;
        else if (en)
            pcnt_n = pcnt_wrap ? 16'd0 : pcnt + 16'd1;

        if (match) begin
            if (auto_reload)
                count_n = 32'd0;
            else
                en_n = 1'b0;
        end else if (tick) begin
            count_n = count + 32'd1;
        end

        if (wr_status && iobus.IOBUS_OUT[0])
            pending_n = 1'b0;
        if (match)
            pending_n = 1'b1;

        if (wr_ctrl) begin
            en_n          = iobus.IOBUS_OUT[0];
            auto_reload_n = iobus.IOBUS_OUT[1];
            irq_en_n      = iobus.IOBUS_OUT[2];
        end
        if (wr_prescale)
            prescale_n = iobus.IOBUS_OUT[15:0];
        if (wr_compare)
            compare_n = iobus.IOBUS_OUT;
        if (wr_count)
            count_n = iobus.IOBUS_OUT;
    end

    // INTR is taken from the registered PENDING/IRQ_EN, so it lags them by a cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 16'd0;
            compare     <= 32'hFFFF_FFFF;
            count       <= 32'd0;
            pcnt        <= 16'd0;
            pending     <= 1'b0;
            rd_data     <= 32'd0;
            intr        <= 1'b0;
        end else begin
            en          <= en_n;
            auto_reload <= auto_reload_n;
            irq_en      <= irq_en_n;
            prescale    <= prescale_n;
            compare     <= compare_n;
            count       <= count_n;
            pcnt        <= pcnt_n;
            pending     <= pending_n;
            rd_data     <= hit ? rd_sel : 32'd0;
            intr        <= pending & irq_en;
        end
    end

    assign iobus.IOBUS_IN = rd_data;
    assign iobus.INTR     = intr;

endmodule
